// File: rtl/dcache_wt_if.sv
// dcache_wt_if: bundles the MEM-stage request port and the backing-memory
// req/ack port of the write-through data cache.
//   slave  : the cache side (takes CPU requests, issues memory requests)
//   master : the environment side (pipeline MEM stage + backing memory)
// CPU side    : cpu_read, cpu_write, cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
// Memory side : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
interface dcache_wt_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with
// one-word lines. Read hits complete combinationally; read misses and all
// writes stall the pipeline until the backing memory acknowledges, followed by
// exactly one RESP cycle in which the held access completes.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   bus        dcache_wt_if.slave (CPU request port + backing-memory port)
//   hit_count  (DCACHE_STATS_EN only) read hits completed in IDLE
//   miss_count (DCACHE_STATS_EN only) read misses entering READ_MISS
// Optional feature macro: DCACHE_STATS_EN (adds the two statistics counters).
module dcache_wt #(
  parameter  int LINES   = 16,
  localparam int INDEX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        reset,
  dcache_wt_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU, RESP} state_t;

  state_t state_reg, state_next;

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Captured request; doubles as the registered memory-side outputs so they
  // stay stable for the whole mem_req period.
  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [29:0] mem_word_reg;
  logic [31:0] mem_wdata_reg;

  logic [INDEX_W-1:0] cpu_index, cap_index;
  logic [TAG_W-1:0]   cpu_tag, cap_tag;
  logic               cpu_hit, cap_hit;
  logic               accept_write, accept_miss, read_hit;
  logic               fill_en, wt_en;
  logic               cpu_stall_next;
  logic [31:0]        cpu_rdata_next;

  // Byte-offset bits never matter for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.cpu_addr[1:0]};

  assign cpu_index = bus.cpu_addr[INDEX_W+1:2];
  assign cpu_tag   = bus.cpu_addr[31:INDEX_W+2];
  assign cap_index = mem_word_reg[INDEX_W-1:0];
  assign cap_tag   = mem_word_reg[29:INDEX_W];

  assign cpu_hit = valid_reg[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  assign cap_hit = valid_reg[cap_index] && (tag_mem[cap_index] == cap_tag);

  // Write wins when read and write are requested together.
  assign accept_write = (state_reg == IDLE) && bus.cpu_write;
  assign read_hit     = (state_reg == IDLE) && bus.cpu_read && !bus.cpu_write && cpu_hit;
  assign accept_miss  = (state_reg == IDLE) && bus.cpu_read && !bus.cpu_write && !cpu_hit;

  // Gated by reset so an ack coinciding with reset cannot touch the arrays.
  assign fill_en = !reset && (state_reg == READ_MISS) && bus.mem_ack;
  assign wt_en   = !reset && (state_reg == WRITE_THRU) && bus.mem_ack && cap_hit;

  always_comb begin
    state_next     = state_reg;
    cpu_stall_next = 1'b0;
    cpu_rdata_next = 32'd0;
    unique case (state_reg)
      IDLE: begin
        if (bus.cpu_write) begin
          cpu_stall_next = 1'b1;
          state_next     = WRITE_THRU;
        end else if (bus.cpu_read) begin
          if (cpu_hit) begin
            cpu_rdata_next = data_mem[cpu_index];
          end else begin
            cpu_stall_next = 1'b1;
            state_next     = READ_MISS;
          end
        end
      end
      READ_MISS, WRITE_THRU: begin
        cpu_stall_next = 1'b1;
        if (bus.mem_ack) state_next = RESP;
      end
      RESP: begin
        // The line was just filled, so a read completes as a hit here.
        if (!mem_we_reg) cpu_rdata_next = data_mem[cap_index];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_word_reg  <= 30'd0;
      mem_wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept_write) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= 1'b1;
        mem_word_reg  <= bus.cpu_addr[31:2];
        mem_wdata_reg <= bus.cpu_wdata;
      end else if (accept_miss) begin
        mem_req_reg  <= 1'b1;
        mem_we_reg   <= 1'b0;
        mem_word_reg <= bus.cpu_addr[31:2];
      end else if ((state_reg == READ_MISS || state_reg == WRITE_THRU) && bus.mem_ack) begin
        mem_req_reg <= 1'b0;
      end
    end
  end

  // Valid bits are the only per-line state that needs clearing on reset.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_reg[gi] <= 1'b0;
      end else if (fill_en && cap_index == INDEX_W'(gi)) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[cap_index]  <= cap_tag;
      data_mem[cap_index] <= bus.mem_rdata;
    end else if (wt_en) begin
      data_mem[cap_index] <= mem_wdata_reg;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (read_hit)    hit_count  <= hit_count + 32'd1;
      if (accept_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_read_hit;
  assign unused_read_hit = read_hit;
`endif

  assign bus.cpu_stall = cpu_stall_next;
  assign bus.cpu_rdata = cpu_rdata_next;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = {mem_word_reg, 2'b00};
  assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: self-checking bench for dcache_wt (LINES=16). A directed
// vector table, hand-written reset/ack corner sequences, then randomized
// accesses checked against a line-occupancy model plus a backing-memory array.
module tb_dcache_wt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_wt_if bus();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_wt #(.LINES(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int total = 0;
  int bad = 0;

  // Backing memory contents, keyed by word address.
  logic [31:0] bmem [int unsigned];

  // Cache model: which word each line holds.
  bit          line_valid [16];
  int unsigned line_word  [16];
  int          exp_hits = 0;
  int          exp_misses = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] seed;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mem_req",   32'(bus.mem_req), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) line_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One MEM-stage access held until the cycle cpu_stall falls; also acts as
  // the backing memory, acking on the delay-th mem_req cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] seed,
                        output int stalls, output logic [31:0] rdata);
    int          reqc;
    int unsigned word;
    bit          seen;
    logic [31:0] obs_addr, obs_wdata, exp_addr;
    logic        obs_we;
    @(negedge clk);
    bus.cpu_read = rd;
    bus.cpu_write = wr;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    #1;
    stalls = 0;
    reqc = 0;
    seen = 1'b0;
    obs_addr = 32'd0;
    obs_wdata = 32'd0;
    obs_we = 1'b0;
    exp_addr = {addr[31:2], 2'b00};
    word = int'(addr >> 2);
    while (bus.cpu_stall === 1'b1 && stalls < 60) begin
      stalls++;
      if (bus.mem_req === 1'b1) begin
        reqc++;
        if (!seen || bus.mem_addr !== exp_addr) obs_addr = bus.mem_addr;
        if (!seen || bus.mem_we !== wr) obs_we = bus.mem_we;
        if (!seen || bus.mem_wdata !== wdata) obs_wdata = bus.mem_wdata;
        seen = 1'b1;
        if (reqc == delay) begin
          bus.mem_ack = 1'b1;
          if (wr) begin
            bmem[word] = wdata;
          end else begin
            if (!bmem.exists(word)) bmem[word] = seed;
            bus.mem_rdata = bmem[word];
          end
        end
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      #1;
    end
    if (stalls >= 60) chk("timeout", 32'd1, 32'd0);
    rdata = bus.cpu_rdata;
    chk("mem_req_low_done", 32'(bus.mem_req), 32'd0);
    if (reqc > 0) begin
      chk("mem_addr", obs_addr, exp_addr);
      chk("mem_we", 32'(obs_we), 32'(wr));
      if (wr) chk("mem_wdata", obs_wdata, wdata);
    end
    $display("txn rd=%0b wr=%0b addr=%h stall=%0d rdata=%h", rd, wr, addr, stalls, rdata);
    @(negedge clk);
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    int          st;
    logic [31:0] rd_v;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;

    // All of these live in line 0 except 0x44 (line 1).
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0042, 32'h0, 1, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1, 32'h0, 2, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0,         0, 32'h1234_5678};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0080, 32'hAAAA_0001, 2, 32'h0, 3, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0,         0, 32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 2, 32'h0,         3, 32'hAAAA_0001};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0440, 32'h0, 1, 32'h5555_0440, 2, 32'h5555_0440};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4, 32'h0,         5, 32'h1234_5678};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 1, 32'h0, 2, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 3, 32'h7777_7777, 4, 32'h0BAD_F00D};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h0,         0, 32'h0BAD_F00D};

    do_reset();

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
             vecs[i].seed, st, rd_v);
      chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp_rdata);
      if (vecs[i].rd && !vecs[i].wr) begin
        if (vecs[i].exp_stall == 0) exp_hits++;
        else exp_misses++;
      end
    end

    // Stray ack while IDLE must not disturb the cache or the state.
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("idle_ack_stall", 32'(bus.cpu_stall), 32'd0);
    chk("idle_ack_req", 32'(bus.mem_req), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h0, st, rd_v);
    chk("idle_ack_hit_stall", 32'(st), 32'd0);
    chk("idle_ack_hit_rdata", rd_v, 32'h0BAD_F00D);
    exp_hits++;

`ifdef DCACHE_STATS_EN
    #1;
    chk("hit_count_dir", hit_count, 32'(exp_hits));
    chk("miss_count_dir", miss_count, 32'(exp_misses));
`endif

    // Reset in the middle of a read miss; the ack arrives afterwards.
    @(negedge clk);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h0000_0100;
    #1;
    chk("mid_stall_idle", 32'(bus.cpu_stall), 32'd1);
    @(negedge clk);
    #1;
    chk("mid_req_on", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    bus.cpu_read = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_req_after_rst", 32'(bus.mem_req), 32'd0);
    chk("mid_stall_after_rst", 32'(bus.cpu_stall), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) line_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(bus.mem_req), 32'd0);
    chk("late_ack_stall", 32'(bus.cpu_stall), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h0000_1100, st, rd_v);
    chk("mid_reread_stall", 32'(st), 32'd3);
    chk("mid_reread_rdata", rd_v, 32'h0000_1100);
    exp_misses++;

    // Randomized phase against the high-level model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int unsigned w, idx;
      int          op, d, exp_st;
      bit          rd, wr, hit;
      logic [31:0] a, wd, exp_rd;
      idx = $urandom_range(0, 15);
      w   = ($urandom_range(0, 3) << 4) | idx;
      if ($urandom_range(0, 3) == 0) w = w | 32'h0040_0000;
      a   = (w << 2) | $urandom_range(0, 3);
      op  = $urandom_range(0, 3);
      rd  = (op == 0 || op == 1 || op == 3);
      wr  = (op >= 2);
      d   = $urandom_range(1, 4);
      wd  = $urandom;
      hit = rd && !wr && line_valid[idx] && line_word[idx] == w;
      exp_st = hit ? 0 : 1 + d;
      access(rd, wr, a, wd, d, $urandom, st, rd_v);
      exp_rd = (wr || !bmem.exists(w)) ? 32'd0 : bmem[w];
      chk("rnd_stall", 32'(st), 32'(exp_st));
      chk("rnd_rdata", rd_v, exp_rd);
      if (rd && !wr) begin
        if (hit) exp_hits++;
        else exp_misses++;
        line_valid[idx] = 1'b1;
        line_word[idx] = w;
      end
    end

`ifdef DCACHE_STATS_EN
    #1;
    chk("hit_count_rnd", hit_count, 32'(exp_hits));
    chk("miss_count_rnd", miss_count, 32'(exp_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's MEM stage (MemRead/MemWrite, dataAddress, data in/out) and a slower backing data memory using a req/ack handshake.
- Read hits return data combinationally with no stall.
- Read misses and all writes raise a stall that freezes the pipeline until backing memory acknowledges.

Parameters:
LINES, 16, number of one-word lines; power of two, >= 2
INDEX_W, $clog2(LINES), index width; derived, do not override

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
cpu_read  input  1  MEM-stage read request (MemRead)
cpu_write  input  1  MEM-stage write request (MemWrite)
cpu_addr  input  32  byte address (dataAddress); bits [1:0] ignored
cpu_wdata  input  32  store data
cpu_rdata  output  32  load data to MEM/WB
cpu_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
mem_req  output  1  backing-memory request, held until mem_ack
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  output  32  write data
mem_ack  input  1  one-cycle completion pulse from backing memory
mem_rdata  input  32  read data; valid in the mem_ack cycle

Behaviour:
- Clock and reset: clk, reset. Reset is synchronous and active-high. On reset: all valid bits cleared, state IDLE, request registers zeroed.
- Output reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_stall=0, cpu_rdata=0.
- Address split:
  - index = addr[INDEX_W+1:2]
  - tag = addr[31:INDEX_W+2]
  - hit = valid[index] && tag_store[index]==tag
- States are IDLE, READ_MISS, WRITE_THRU, RESP.
- IDLE, no request: cpu_stall=0, cpu_rdata=0.
- IDLE, cpu_read with hit: cpu_rdata=data[index] combinationally; cpu_stall=0; stay IDLE.
- IDLE, cpu_read with miss:
  - cpu_stall=1 combinationally.
  - Capture addr; go to READ_MISS.
  - mem_req=1, mem_we=0 from the next cycle.
- IDLE, cpu_write:
  - cpu_stall=1.
  - Capture addr and wdata; go to WRITE_THRU.
  - mem_req=1, mem_we=1 from the next cycle.
  - If cpu_read and cpu_write are both high, write wins.
- READ_MISS: cpu_stall=1. On mem_ack: line[index] <= {valid=1, tag, mem_rdata}; mem_req drops next cycle; go to RESP.
- WRITE_THRU: cpu_stall=1. On mem_ack: if the captured address hits, update the line data (no-write-allocate: a miss leaves the line untouched); go to RESP.
- RESP:
  - Exactly one cycle with cpu_stall=0, so the held MEM-stage access completes exactly once.
  - Read: cpu_rdata=data[captured index], which now hits.
  - Write: cpu_rdata=0.
  - Go to IDLE. A request present in RESP is not re-issued.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss: stall cycles = 1 + N, where N = number of READ_MISS cycles until mem_ack inclusive; data is delivered in RESP.
  - Write: the same stall count as a read miss.
- mem_addr, mem_we and mem_wdata are registered and remain stable for the whole of each mem_req period.
- mem_ack is ignored in IDLE and RESP; it must not corrupt the cache or the state.
- Reset during READ_MISS or WRITE_THRU: the transaction is abandoned, mem_req=0 the next cycle, and no line is written. A late mem_ack is ignored.
- Index wrap: addresses differing only in tag map to the same line; a fill evicts the old tag silently. There is no dirty state (write-through).

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, two extra outputs exist:
  - hit_count[31:0] increments once per read hit completed in IDLE.
  - miss_count[31:0] increments once per read miss on entry to READ_MISS.
  - Both are zeroed by reset and wrap modulo 2^32. Writes are not counted.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold read miss: after reset, cpu_read addr 0x0000_0040, mem_ack 3 cycles after mem_req with mem_rdata 0xDEAD_BEEF -> mem_req=1 mem_we=0 mem_addr=0x40; cpu_stall high 4 cycles; RESP gives cpu_rdata=0xDEAD_BEEF; mem_req=0.
- Read hit: repeat read 0x40 -> cpu_rdata=0xDEAD_BEEF same cycle, cpu_stall=0, mem_req stays 0.
- Write-through hit: cpu_write 0x40, wdata 0x1234_5678, ack after 1 cycle -> mem_we=1 mem_wdata=0x1234_5678; the next read of 0x40 hits with 0x1234_5678.
- No-write-allocate and conflict (LINES=16): write 0x80 (miss) -> memory write only; read 0x80 misses. Read 0x440 (same index 0 as 0x40... index 0x10>>2 wraps) evicts; a subsequent read of 0x40 misses again.
- Reset mid-miss: assert reset during READ_MISS, ack arrives 2 cycles later -> mem_req=0 after reset; the ack is ignored; reading the same address misses again.
- Simultaneous read+write plus stats (DCACHE_STATS_EN): both asserted -> treated as write. After the sequence above, hit_count and miss_count match the counted events exactly.
